// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between FETCH, EXEC and DMA: DMA has priority and may lock
// the bus, FETCH/EXEC alternate round-robin, and read data is routed back to its issuer.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8,
  parameter int LOCK_MAX   = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  exec_req,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [REG_WIDTH-1:0]  exec_wdata,
  input  logic [REG_WIDTH-1:0]  dma_wdata,
  input  logic                  exec_we,
  input  logic                  dma_we,
  input  logic                  dma_lock,
  output logic                  fetch_gnt,
  output logic                  exec_gnt,
  output logic                  dma_gnt,
  output logic                  fetch_rvalid,
  output logic                  exec_rvalid,
  output logic                  dma_rvalid,
  output logic [REG_WIDTH-1:0]  rdata_out,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  lock_timeout
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [CNT_W-1:0] COOL_LEN  = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [1:0] {IDLE, SHARED, DMA_LOCKED} state_t;

  state_t                state_q;
  logic                  rr_exec_q;   // 1: EXEC is favoured when both FETCH and EXEC request
  logic [CNT_W-1:0]      lock_cnt_q;
  logic [CNT_W-1:0]      cool_q;
  logic                  timeout_q;
  logic                  fetch_gnt_q, exec_gnt_q, dma_gnt_q;
  logic                  fetch_rv_q, exec_rv_q, dma_rv_q;
  logic                  mem_en_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [REG_WIDTH-1:0]  mem_wdata_q, rdata_q;

  logic lock_hold_d, forced_d, guard_d, enter_d;
  logic win_f_d, win_e_d, win_d_d;

  // Arbitration decision for the edge about to happen. On a forced release DMA
  // yields that one slot so a waiting FETCH/EXEC actually gets through.
  always_comb begin
    lock_hold_d = (state_q == DMA_LOCKED) && dma_lock;
    forced_d    = lock_hold_d && (lock_cnt_q == LOCK_LAST);
    guard_d     = (cool_q != '0) && (fetch_req || exec_req);
    win_f_d     = 1'b0;
    win_e_d     = 1'b0;
    win_d_d     = 1'b0;
    if (lock_hold_d && !forced_d) begin
      win_d_d = dma_req;
    end else if (dma_req && !(forced_d && (fetch_req || exec_req))) begin
      win_d_d = 1'b1;
    end else if (fetch_req && (!exec_req || !rr_exec_q)) begin
      win_f_d = 1'b1;
    end else if (exec_req) begin
      win_e_d = 1'b1;
    end
    enter_d = win_d_d && dma_lock && !(lock_hold_d && !forced_d) && !guard_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_exec_q   <= 1'b0;
      lock_cnt_q  <= '0;
      cool_q      <= '0;
      timeout_q   <= 1'b0;
      fetch_gnt_q <= 1'b0;
      exec_gnt_q  <= 1'b0;
      dma_gnt_q   <= 1'b0;
      fetch_rv_q  <= 1'b0;
      exec_rv_q   <= 1'b0;
      dma_rv_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      // Read return for the transfer issued in the previous cycle
      fetch_rv_q <= fetch_gnt_q;
      exec_rv_q  <= exec_gnt_q && !mem_we_q;
      dma_rv_q   <= dma_gnt_q && !mem_we_q;
      if (fetch_gnt_q || ((exec_gnt_q || dma_gnt_q) && !mem_we_q)) begin
        rdata_q <= mem_rdata;
      end

      if (lock_hold_d && !forced_d) begin
        state_q <= DMA_LOCKED;
        if (lock_cnt_q != CNT_SAT) lock_cnt_q <= lock_cnt_q + 1'b1;
      end else if (enter_d) begin
        state_q    <= DMA_LOCKED;
        lock_cnt_q <= '0;
      end else begin
        state_q <= (win_f_d || win_e_d || win_d_d) ? SHARED : IDLE;
      end

      if (forced_d) begin
        timeout_q <= 1'b1;
        cool_q    <= COOL_LEN;
      end else if (cool_q != '0) begin
        cool_q <= cool_q - 1'b1;
      end

      if (win_f_d) rr_exec_q <= 1'b1;
      if (win_e_d) rr_exec_q <= 1'b0;

      fetch_gnt_q <= win_f_d;
      exec_gnt_q  <= win_e_d;
      dma_gnt_q   <= win_d_d;
      mem_en_q    <= win_f_d || win_e_d || win_d_d;
      mem_we_q    <= (win_e_d && exec_we) || (win_d_d && dma_we);
      if (win_f_d) begin
        mem_addr_q <= fetch_addr;
      end else if (win_e_d) begin
        mem_addr_q  <= exec_addr;
        mem_wdata_q <= exec_wdata;
      end else if (win_d_d) begin
        mem_addr_q  <= dma_addr;
        mem_wdata_q <= dma_wdata;
      end
    end
  end

  assign fetch_gnt    = fetch_gnt_q;
  assign exec_gnt     = exec_gnt_q;
  assign dma_gnt      = dma_gnt_q;
  assign fetch_rvalid = fetch_rv_q;
  assign exec_rvalid  = exec_rv_q;
  assign dma_rvalid   = dma_rv_q;
  assign rdata_out    = rdata_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign lock_timeout = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle model of the arbitration rules is
// compared against every output each cycle, plus literal checks at key points.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LM = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fetch_req = 0, exec_req = 0, dma_req = 0;
  logic [AW-1:0] fetch_addr = '0, exec_addr = '0, dma_addr = '0;
  logic [DW-1:0] exec_wdata = '0, dma_wdata = '0, mem_rdata = '0;
  logic exec_we = 0, dma_we = 0, dma_lock = 0;
  logic fetch_gnt, exec_gnt, dma_gnt, fetch_rvalid, exec_rvalid, dma_rvalid;
  logic [DW-1:0] rdata_out, mem_wdata;
  logic mem_en, mem_we, lock_timeout;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .REG_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .exec_req(exec_req), .dma_req(dma_req),
    .fetch_addr(fetch_addr), .exec_addr(exec_addr), .dma_addr(dma_addr),
    .exec_wdata(exec_wdata), .dma_wdata(dma_wdata),
    .exec_we(exec_we), .dma_we(dma_we), .dma_lock(dma_lock),
    .fetch_gnt(fetch_gnt), .exec_gnt(exec_gnt), .dma_gnt(dma_gnt),
    .fetch_rvalid(fetch_rvalid), .exec_rvalid(exec_rvalid), .dma_rvalid(dma_rvalid),
    .rdata_out(rdata_out), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the bus, how long the lock has lasted, the
  // cool-down window after a forced release, and who was served last.
  bit started = 0;
  bit m_locked, m_lastE, m_to;
  int m_age, m_cool;
  bit e_fg, e_eg, e_dg, e_fv, e_ev, e_dv, e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd;

  always @(posedge clk) begin
    int w;
    bit hold, force_rel, other, nf, ne, nd;
    if (reset) begin
      started = 1;
      m_locked = 0; m_lastE = 1; m_to = 0; m_age = 0; m_cool = 0;
      {e_fg, e_eg, e_dg, e_fv, e_ev, e_dv, e_en, e_we} = '0;
      e_addr = '0; e_wd = '0; e_rd = '0;
    end else begin
      nf = e_fg; ne = e_eg && !e_we; nd = e_dg && !e_we;
      if (nf || ne || nd) e_rd = mem_rdata;
      e_fv = nf; e_ev = ne; e_dv = nd;
      other = fetch_req || exec_req;
      hold = m_locked && dma_lock;
      force_rel = hold && (m_age == LM - 1);
      w = 0;
      if (hold && !force_rel) begin
        if (dma_req) w = 3;
        m_age++;
      end else begin
        m_locked = 0;
        if (dma_req && !(force_rel && other)) w = 3;
        else if (fetch_req && exec_req) w = m_lastE ? 1 : 2;
        else if (fetch_req) w = 1;
        else if (exec_req) w = 2;
        if (w == 3 && dma_lock && !(m_cool > 0 && other)) begin
          m_locked = 1; m_age = 0;
        end
      end
      if (force_rel) begin m_to = 1; m_cool = LM; end
      else if (m_cool > 0) m_cool--;
      if (w == 1) m_lastE = 0;
      if (w == 2) m_lastE = 1;
      e_fg = (w == 1); e_eg = (w == 2); e_dg = (w == 3);
      e_en = (w != 0);
      e_we = (w == 2 && exec_we) || (w == 3 && dma_we);
      case (w)
        1: e_addr = fetch_addr;
        2: begin e_addr = exec_addr; e_wd = exec_wdata; end
        3: begin e_addr = dma_addr; e_wd = dma_wdata; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("fetch_gnt", fetch_gnt, e_fg);
      chk("exec_gnt", exec_gnt, e_eg);
      chk("dma_gnt", dma_gnt, e_dg);
      chk("fetch_rvalid", fetch_rvalid, e_fv);
      chk("exec_rvalid", exec_rvalid, e_ev);
      chk("dma_rvalid", dma_rvalid, e_dv);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("rdata_out", rdata_out, e_rd);
      chk("lock_timeout", lock_timeout, m_to);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_reqs();
    fetch_req = 0; exec_req = 0; dma_req = 0; dma_lock = 0;
    exec_we = 0; dma_we = 0;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1;
    step(2);
    reset = 0;
  endtask

  initial begin
    step(2);
    reset = 0;
    chk("reset_gnts", {fetch_gnt, exec_gnt, dma_gnt, mem_en}, 4'b0000);
    chk("reset_addr", mem_addr, 16'h0000);
    chk("reset_timeout", lock_timeout, 1'b0);

    // Single FETCH read
    fetch_req = 1; fetch_addr = 16'hC000; mem_rdata = 8'hA9;
    step(1);
    fetch_req = 0;
    chk("t1_fetch_gnt", fetch_gnt, 1'b1);
    chk("t1_addr", mem_addr, 16'hC000);
    chk("t1_we", mem_we, 1'b0);
    step(1);
    chk("t1_rvalid", fetch_rvalid, 1'b1);
    chk("t1_rdata", rdata_out, 8'hA9);
    chk("t1_others", {exec_gnt, dma_gnt, exec_rvalid, dma_rvalid, fetch_gnt}, 5'b0);
    step(2);

    // FETCH/EXEC alternation, EXEC writes
    do_reset();
    fetch_req = 1; exec_req = 1; fetch_addr = 16'h1000; exec_addr = 16'h2000;
    exec_we = 1; exec_wdata = 8'h55; mem_rdata = 8'h3C;
    step(1);
    chk("t2_first_fetch", {fetch_gnt, exec_gnt}, 2'b10);
    step(1);
    chk("t2_exec", {fetch_gnt, exec_gnt}, 2'b01);
    chk("t2_exec_wr", {mem_we, mem_wdata}, {1'b1, 8'h55});
    step(1);
    chk("t2_fetch_again", {fetch_gnt, exec_gnt}, 2'b10);
    step(1);
    chk("t2_exec_again", {fetch_gnt, exec_gnt, exec_rvalid}, 3'b010);
    step(1);
    chk("t2_no_exec_rvalid", exec_rvalid, 1'b0);
    clear_reqs();
    step(2);

    // DMA priority without lock
    do_reset();
    dma_req = 1; fetch_req = 1; exec_req = 1; dma_addr = 16'h0300; dma_wdata = 8'hE1;
    dma_we = 1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t3_dma_wins", {dma_gnt, fetch_gnt, exec_gnt}, 3'b100);
    end
    dma_req = 0;
    step(1);
    chk("t3_fetch_after_dma", {dma_gnt, fetch_gnt, exec_gnt}, 3'b010);
    clear_reqs();
    step(2);

    // Lock with gaps in dma_req
    do_reset();
    fetch_req = 1; dma_req = 1; dma_lock = 1; dma_we = 0; mem_rdata = 8'h77;
    step(1);
    chk("t4_dma_enter", dma_gnt, 1'b1);
    dma_req = 0;
    step(1);
    chk("t4_gap_no_gnt", {dma_gnt, fetch_gnt, mem_en}, 3'b000);
    dma_req = 1;
    step(1);
    chk("t4_dma_again", {dma_gnt, fetch_gnt}, 2'b10);
    dma_lock = 0; dma_req = 0;
    step(1);
    chk("t4_fetch_after_unlock", {dma_gnt, fetch_gnt}, 2'b01);
    clear_reqs();
    step(2);

    // Forced release after LOCK_MAX locked cycles
    do_reset();
    dma_req = 1; dma_lock = 1; exec_req = 1; exec_we = 0; dma_addr = 16'h4400;
    for (int i = 0; i < LM; i++) begin
      step(1);
      chk("t5_locked_dma", {dma_gnt, exec_gnt, lock_timeout}, 3'b100);
    end
    step(1);
    chk("t5_forced_exec", {dma_gnt, exec_gnt, lock_timeout}, 3'b011);
    step(1);
    chk("t5_dma_plain", {dma_gnt, exec_gnt}, 2'b10);
    dma_req = 0;
    step(1);
    chk("t5_relock_blocked", {dma_gnt, exec_gnt, lock_timeout}, 3'b011);
    dma_req = 1;
    step(1);
    chk("t5_sticky", lock_timeout, 1'b1);
    clear_reqs();
    step(2);

    // Reset during a locked DMA read
    do_reset();
    dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 16'hBEEF; mem_rdata = 8'h5A;
    step(1);
    chk("t6_dma_read", {dma_gnt, mem_we}, 2'b10);
    reset = 1;
    step(1);
    chk("t6_no_rvalid", dma_rvalid, 1'b0);
    chk("t6_reset_vals", {dma_gnt, mem_en, mem_addr, rdata_out}, 27'd0);
    reset = 0; clear_reqs(); fetch_req = 1; fetch_addr = 16'h0042;
    step(1);
    chk("t6_idle_then_fetch", {fetch_gnt, dma_gnt}, 2'b10);
    fetch_req = 0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single CPU memory port between three requesters: instruction fetcher (FETCH), execute unit (EXEC) and OAM DMA engine (DMA).
- Issues one memory transfer per cycle and routes read data back to the issuing requester.
- DMA has priority and may lock the bus for bursts; FETCH and EXEC alternate round-robin.
- Sits between the CPU core units and the system memory map.

Parameters:
- ADDR_WIDTH, 16, address width.
- REG_WIDTH, 8, data width.
- LOCK_MAX, 512, maximum consecutive DMA-locked cycles before forced release.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fetch_req, exec_req, dma_req  in  1 each  transfer request; held with its address/data until the matching gnt.
- fetch_addr, exec_addr, dma_addr  in  ADDR_WIDTH each  request address.
- exec_wdata, dma_wdata  in  REG_WIDTH each  write data (FETCH is read-only).
- exec_we, dma_we  in  1 each  1 = write, 0 = read.
- dma_lock  in  1  hold the bus for DMA while high.
- fetch_gnt, exec_gnt, dma_gnt  out  1 each  one-cycle grant pulse; the request is issued in that cycle.
- fetch_rvalid, exec_rvalid, dma_rvalid  out  1 each  read data valid for that requester.
- rdata_out  out  REG_WIDTH  read data, shared by all requesters.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  REG_WIDTH  memory write data.
- mem_rdata  in  REG_WIDTH  memory read data, valid one cycle after a read with mem_en.
- lock_timeout  out  1  sticky flag: forced lock release occurred.

Behaviour:
- Reset: all gnt, rvalid, mem_en, mem_we and lock_timeout are 0; mem_addr, mem_wdata and rdata_out are 0; round-robin pointer favours FETCH; lock counter is 0; state is IDLE. A reset mid-transfer drops any pending rvalid.
- All outputs are registered.
- Request timing:
  - Requests are sampled at posedge N.
  - The winner's gnt and mem_en/mem_we/mem_addr/mem_wdata are asserted in cycle N+1.
  - For a read, rdata_out is loaded from mem_rdata and the owner's rvalid pulses in cycle N+2.
- Throughput and stability:
  - Back-to-back grants are allowed: one transfer per cycle.
  - A requester that keeps req high after its gnt has made a new request.
  - Addresses and data are captured at the sampling edge, so a requester may change them in its gnt cycle.
- At most one gnt is high per cycle. mem_en is high exactly when a gnt is high.
- States:
  - IDLE: no grant.
  - SHARED: normal arbitration.
  - DMA_LOCKED: bus held for DMA.
- Priority in IDLE/SHARED:
  - dma_req wins.
  - Otherwise FETCH/EXEC are round-robin: if both request, grant the one not served last.
  - A single requester always wins. The pointer updates only on a FETCH or EXEC grant.
- Entering DMA_LOCKED: a DMA grant with dma_lock=1 moves to DMA_LOCKED and clears the lock counter.
- In DMA_LOCKED:
  - Only DMA can be granted.
  - Cycles with dma_req=0 produce no grant, and FETCH/EXEC still wait.
  - The counter increments every cycle.
  - Exit to SHARED/IDLE when dma_lock=0, evaluated at the same edge with normal priority.
- Forced release: when the counter reaches LOCK_MAX-1, the arbiter forces exit and sets lock_timeout.
  - For the next LOCK_MAX cycles, a fresh lock cannot re-enter DMA_LOCKED while FETCH or EXEC is requesting.
  - DMA keeps plain priority during this period.
  - lock_timeout clears only on reset.
- Simultaneous events:
  - dma_lock rising while a FETCH/EXEC grant is being issued: that grant completes, and the lock applies from the next DMA win.
  - dma_req dropping in the same edge as its gnt is legal.
- No requests: IDLE, mem_en=0; mem_addr holds its last value.
- Width rules: no arithmetic on address or data. The lock counter is clog2(LOCK_MAX)+1 bits and saturates.

Test Plan:
- Reset, then fetch_req=1, fetch_addr=16'hC000, mem_rdata=8'hA9 -> fetch_gnt at N+1 with mem_addr=C000, mem_we=0; fetch_rvalid and rdata_out=A9 at N+2; all other gnt/rvalid stay 0.
- fetch_req and exec_req held high continuously -> grants alternate F,E,F,E starting with FETCH; exec_we=1, exec_wdata=8'h55 gives mem_we=1, mem_wdata=55 and no exec_rvalid.
- dma_req, fetch_req and exec_req all high, dma_lock=0 -> DMA granted every cycle; FETCH/EXEC are granted only after dma_req drops.
- dma_lock=1 with dma_req toggling 1,0,1 and fetch_req high -> no fetch_gnt during the lock, including dma_req=0 cycles; fetch_gnt comes one cycle after dma_lock falls.
- LOCK_MAX=8, dma_lock and dma_req held high, exec_req high -> exec_gnt after 8 locked cycles, lock_timeout=1; a re-lock is blocked while exec_req is high.
- Reset asserted during a DMA_LOCKED read -> no rvalid next cycle; all outputs at reset values; state IDLE.
